// File: rtl/hazard_tag_pipe_if.sv
// Signal bundle between the ID/EX/MEM control path and the hazard/tag pipeline.
// The pipeline block is the slave; the core datapath (or a bench) is the master.
interface hazard_tag_pipe_if;
  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 16;

  logic [REG_W-1:0] IF_ID_Rs1;
  logic [REG_W-1:0] IF_ID_Rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [REG_W-1:0] id_rd;
  logic             id_regwrite;
  logic             id_memread;
  logic             id_memacc;
  logic             ex_branch_taken;
  logic             mem_ready;

  logic [REG_W-1:0] ID_EX_Rd;
  logic [REG_W-1:0] EX_MEM_Rd;
  logic [REG_W-1:0] MEM_WB_Rd;
  logic             ID_EX_RegWrite;
  logic             EX_MEM_RegWrite;
  logic             MEM_WB_RegWrite;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic [CNT_W-1:0] stall_cycles;
  logic             mem_timeout;

  modport slave (
    input  IF_ID_Rs1, IF_ID_Rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_regwrite, id_memread, id_memacc, ex_branch_taken, mem_ready,
    output ID_EX_Rd, EX_MEM_Rd, MEM_WB_Rd, ID_EX_RegWrite, EX_MEM_RegWrite,
           MEM_WB_RegWrite, pc_write, if_id_write, if_id_flush, id_ex_bubble,
           stall_cycles, mem_timeout
  );

  modport master (
    output IF_ID_Rs1, IF_ID_Rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_regwrite, id_memread, id_memacc, ex_branch_taken, mem_ready,
    input  ID_EX_Rd, EX_MEM_Rd, MEM_WB_Rd, ID_EX_RegWrite, EX_MEM_RegWrite,
           MEM_WB_RegWrite, pc_write, if_id_write, if_id_flush, id_ex_bubble,
           stall_cycles, mem_timeout
  );
endinterface

// File: rtl/hazard_tag_pipe.sv
// Destination-tag pipeline (ID/EX, EX/MEM, MEM/WB) with load-use, branch-flush
// and memory-freeze hazard control, stall counter and sticky memory timeout.
module hazard_tag_pipe #(
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  hazard_tag_pipe_if.slave bus
);
  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 16;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             memread;
    logic             memacc;
  } id_ex_t;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             memacc;
  } ex_mem_t;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             regwrite;
  } mem_wb_t;

  typedef enum logic {RUN, MEM_WAIT} state_t;

  id_ex_t           id_ex_q, id_ex_d;
  ex_mem_t          ex_mem_q, ex_mem_d;
  mem_wb_t          mem_wb_q, mem_wb_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             timeout_q, timeout_d;

  logic freeze_c;
  logic load_use_c;
  logic pc_write_c;

  // Hazard detection and control enables; freeze dominates, then branch, then load-use.
  always_comb begin
    freeze_c   = ex_mem_q.memacc & ~bus.mem_ready;
    load_use_c = id_ex_q.memread && (id_ex_q.rd != '0) &&
                 ((bus.id_uses_rs1 && (id_ex_q.rd == bus.IF_ID_Rs1)) ||
                  (bus.id_uses_rs2 && (id_ex_q.rd == bus.IF_ID_Rs2)));
    pc_write_c       = ~(freeze_c | (~bus.ex_branch_taken & load_use_c));
    bus.pc_write     = pc_write_c;
    bus.if_id_write  = pc_write_c;
    bus.if_id_flush  = ~freeze_c & bus.ex_branch_taken;
    bus.id_ex_bubble = ~freeze_c & (bus.ex_branch_taken | load_use_c);
  end

  // Tag pipeline next state.
  always_comb begin
    id_ex_d  = id_ex_q;
    ex_mem_d = ex_mem_q;
    mem_wb_d = mem_wb_q;
    if (freeze_c) begin
      mem_wb_d = '0;
    end else begin
      ex_mem_d = '{rd: id_ex_q.rd, regwrite: id_ex_q.regwrite, memacc: id_ex_q.memacc};
      mem_wb_d = '{rd: ex_mem_q.rd, regwrite: ex_mem_q.regwrite};
      if (bus.ex_branch_taken || load_use_c) begin
        id_ex_d = '0;
      end else begin
        // A write to x0 is architecturally dead, so it never raises RegWrite.
        id_ex_d = '{rd:       bus.id_rd,
                    regwrite: bus.id_regwrite & (bus.id_rd != '0),
                    memread:  bus.id_memread,
                    memacc:   bus.id_memacc};
      end
    end
  end

  // Memory-wait FSM, timeout flag and stall counter.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    stall_d    = stall_q;
    unique case (state_q)
      RUN: begin
        if (freeze_c) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = CNT_W'(1);
        end else begin
          wait_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (bus.mem_ready) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q != '1) begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = RUN;
    endcase
    timeout_d = timeout_q | (wait_cnt_d == CNT_W'(MEM_TIMEOUT));
    if (!pc_write_c && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_q    <= '0;
      ex_mem_q   <= '0;
      mem_wb_q   <= '0;
      state_q    <= RUN;
      wait_cnt_q <= '0;
      stall_q    <= '0;
      timeout_q  <= 1'b0;
    end else begin
      id_ex_q    <= id_ex_d;
      ex_mem_q   <= ex_mem_d;
      mem_wb_q   <= mem_wb_d;
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      stall_q    <= stall_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.ID_EX_Rd        = id_ex_q.rd;
  assign bus.ID_EX_RegWrite  = id_ex_q.regwrite;
  assign bus.EX_MEM_Rd       = ex_mem_q.rd;
  assign bus.EX_MEM_RegWrite = ex_mem_q.regwrite;
  assign bus.MEM_WB_Rd       = mem_wb_q.rd;
  assign bus.MEM_WB_RegWrite = mem_wb_q.regwrite;
  assign bus.stall_cycles    = stall_q;
  assign bus.mem_timeout     = timeout_q;
endmodule

// File: tb/tb_hazard_tag_pipe.sv
// Directed bench for hazard_tag_pipe: each vector queues its expected per-cycle
// snapshot, and a negedge monitor pops and compares it against the DUT.
module tb_hazard_tag_pipe;
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       mrd;
    logic       macc;
    logic       br;
    logic       rdy;
  } stim_t;

  typedef struct packed {
    logic [4:0]  ide;
    logic        rwe;
    logic [4:0]  exm;
    logic        rwm;
    logic [4:0]  mwb;
    logic        rww;
    logic [3:0]  ctl;  // {pc_write, if_id_write, if_id_flush, id_ex_bubble}
    logic [15:0] st;
    logic        to;
  } exp_t;

  localparam logic [3:0] RUN = 4'b1100;
  localparam logic [3:0] LU  = 4'b0001;
  localparam logic [3:0] BR  = 4'b1111;
  localparam logic [3:0] FRZ = 4'b0000;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t  exp_q[$];
  string name_q[$];

  hazard_tag_pipe_if bus ();

  hazard_tag_pipe #(.MEM_TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t s(input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2, input logic [4:0] rd,
                              input logic rw, input logic mrd, input logic macc,
                              input logic br, input logic rdy);
    stim_t r;
    r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2; r.rd = rd;
    r.rw = rw; r.mrd = mrd; r.macc = macc; r.br = br; r.rdy = rdy;
    return r;
  endfunction

  function automatic exp_t e(input logic [4:0] ide, input logic rwe,
                             input logic [4:0] exm, input logic rwm,
                             input logic [4:0] mwb, input logic rww,
                             input logic [3:0] ctl, input int st, input logic to);
    exp_t r;
    r.ide = ide; r.rwe = rwe; r.exm = exm; r.rwm = rwm; r.mwb = mwb; r.rww = rww;
    r.ctl = ctl; r.st = 16'(st); r.to = to;
    return r;
  endfunction

  task automatic drive(input stim_t si);
    bus.IF_ID_Rs1       = si.rs1;
    bus.IF_ID_Rs2       = si.rs2;
    bus.id_uses_rs1     = si.u1;
    bus.id_uses_rs2     = si.u2;
    bus.id_rd           = si.rd;
    bus.id_regwrite     = si.rw;
    bus.id_memread      = si.mrd;
    bus.id_memacc       = si.macc;
    bus.ex_branch_taken = si.br;
    bus.mem_ready       = si.rdy;
  endtask

  // Inputs change just after a rising edge; the expectation covers that cycle.
  task automatic step(input string nm, input stim_t si, input exp_t ex);
    @(posedge clk);
    #1;
    drive(si);
    exp_q.push_back(ex);
    name_q.push_back(nm);
  endtask

  // Monitor: compare the DUT snapshot with the oldest pending expectation.
  initial begin
    exp_t  want;
    exp_t  got;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        nm   = name_q.pop_front();
        got.ide = bus.ID_EX_Rd;   got.rwe = bus.ID_EX_RegWrite;
        got.exm = bus.EX_MEM_Rd;  got.rwm = bus.EX_MEM_RegWrite;
        got.mwb = bus.MEM_WB_Rd;  got.rww = bus.MEM_WB_RegWrite;
        got.ctl = {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble};
        got.st  = bus.stall_cycles;
        got.to  = bus.mem_timeout;
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL %s: got ide=%0d/%0b exm=%0d/%0b mwb=%0d/%0b ctl=%b st=%0d to=%b ; need ide=%0d/%0b exm=%0d/%0b mwb=%0d/%0b ctl=%b st=%0d to=%b",
                   nm, got.ide, got.rwe, got.exm, got.rwm, got.mwb, got.rww, got.ctl, got.st, got.to,
                   want.ide, want.rwe, want.exm, want.rwm, want.mwb, want.rww, want.ctl, want.st, want.to);
        end
      end
    end
  end

  initial begin
    stim_t idle;
    stim_t lw7;
    stim_t sw;
    checks = 0;
    errors = 0;
    idle = s(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    lw7  = s(0, 0, 0, 0, 7, 1, 1, 1, 0, 1);
    sw   = s(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    rst_n = 1'b0;
    drive(idle);

    // Reset values; flush/bubble follow ex_branch_taken even in reset
    step("rst_branch", s(0, 0, 0, 0, 0, 0, 0, 0, 1, 1), e(0, 0, 0, 0, 0, 0, BR, 0, 0));
    step("rst_idle",   idle,                            e(0, 0, 0, 0, 0, 0, RUN, 0, 0));
    @(negedge clk); #2 rst_n = 1'b1;

    // Normal advance, x0 gating
    step("adv_id",   s(0, 0, 0, 0, 5, 1, 0, 0, 0, 1), e(0, 0, 0, 0, 0, 0, RUN, 0, 0));
    step("adv_ex",   idle,                            e(5, 1, 0, 0, 0, 0, RUN, 0, 0));
    step("adv_mem",  idle,                            e(0, 0, 5, 1, 0, 0, RUN, 0, 0));
    step("adv_wb",   idle,                            e(0, 0, 0, 0, 5, 1, RUN, 0, 0));
    step("x0_id",    s(0, 0, 0, 0, 0, 1, 0, 0, 0, 1), e(0, 0, 0, 0, 0, 0, RUN, 0, 0));
    step("x0_gated", idle,                            e(0, 0, 0, 0, 0, 0, RUN, 0, 0));

    // Load-use hazard and its non-stalling variants
    step("lu_load",     lw7,                              e(0, 0, 0, 0, 0, 0, RUN, 0, 0));
    step("lu_stall",    s(7, 0, 1, 0, 8, 1, 0, 0, 0, 1),  e(7, 1, 0, 0, 0, 0, LU, 0, 0));
    step("lu_release",  s(7, 0, 1, 0, 8, 1, 0, 0, 0, 1),  e(0, 0, 7, 1, 0, 0, RUN, 1, 0));
    step("lu_after",    idle,                             e(8, 1, 0, 0, 7, 1, RUN, 1, 0));
    step("nouse_load",  lw7,                              e(0, 0, 8, 1, 0, 0, RUN, 1, 0));
    step("nouse_rs1",   s(7, 3, 0, 1, 9, 1, 0, 0, 0, 1),  e(7, 1, 0, 0, 8, 1, RUN, 1, 0));
    step("x0_load",     s(0, 0, 0, 0, 0, 1, 1, 1, 0, 1),  e(9, 1, 7, 1, 0, 0, RUN, 1, 0));
    step("x0_nostall",  s(0, 0, 1, 1, 4, 1, 0, 0, 0, 1),  e(0, 0, 9, 1, 7, 1, RUN, 1, 0));
    step("x0_after",    idle,                             e(4, 1, 0, 0, 9, 1, RUN, 1, 0));

    // Branch coincident with load-use: branch handling only
    step("br_load",     lw7,                              e(0, 0, 4, 1, 0, 0, RUN, 1, 0));
    step("br_lu",       s(7, 0, 1, 0, 8, 1, 0, 0, 1, 1),  e(7, 1, 0, 0, 4, 1, BR, 1, 0));
    step("br_after",    idle,                             e(0, 0, 7, 1, 0, 0, RUN, 1, 0));

    // Memory wait: store in EX/MEM with mem_ready low for 3 cycles, branch ignored
    step("mw_add3",     s(0, 0, 0, 0, 3, 1, 0, 0, 0, 1),  e(0, 0, 0, 0, 7, 1, RUN, 1, 0));
    step("mw_store",    sw,                               e(3, 1, 0, 0, 0, 0, RUN, 1, 0));
    step("mw_add6",     s(0, 0, 0, 0, 6, 1, 0, 0, 0, 1),  e(0, 0, 3, 1, 0, 0, RUN, 1, 0));
    step("mw_frz1",     s(0, 0, 0, 0, 10, 1, 0, 0, 1, 0), e(6, 1, 0, 0, 3, 1, FRZ, 1, 0));
    step("mw_frz2",     s(0, 0, 0, 0, 10, 1, 0, 0, 1, 0), e(6, 1, 0, 0, 0, 0, FRZ, 2, 0));
    step("mw_frz3",     s(0, 0, 0, 0, 10, 1, 0, 0, 1, 0), e(6, 1, 0, 0, 0, 0, FRZ, 3, 0));
    step("mw_branch",   s(0, 0, 0, 0, 10, 1, 0, 0, 1, 1), e(6, 1, 0, 0, 0, 0, BR, 4, 0));
    step("mw_after",    idle,                             e(0, 0, 6, 1, 0, 0, RUN, 4, 0));

    // Timeout at wait_cnt == 4, sticky after mem_ready returns
    step("to_store",    sw,                               e(0, 0, 0, 0, 6, 1, RUN, 4, 0));
    step("to_idle",     idle,                             e(0, 0, 0, 0, 0, 0, RUN, 4, 0));
    step("to_w1",       s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),  e(0, 0, 0, 0, 0, 0, FRZ, 4, 0));
    step("to_w2",       s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),  e(0, 0, 0, 0, 0, 0, FRZ, 5, 0));
    step("to_w3",       s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),  e(0, 0, 0, 0, 0, 0, FRZ, 6, 0));
    step("to_w4",       s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),  e(0, 0, 0, 0, 0, 0, FRZ, 7, 0));
    step("to_w5",       s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),  e(0, 0, 0, 0, 0, 0, FRZ, 8, 1));
    step("to_ready",    idle,                             e(0, 0, 0, 0, 0, 0, RUN, 9, 1));
    step("to_sticky",   idle,                             e(0, 0, 0, 0, 0, 0, RUN, 9, 1));

    // Async reset mid-freeze, asserted between clock edges
    step("rf_add12",    s(0, 0, 0, 0, 12, 1, 0, 0, 0, 1), e(0, 0, 0, 0, 0, 0, RUN, 9, 1));
    step("rf_store",    sw,                               e(12, 1, 0, 0, 0, 0, RUN, 9, 1));
    step("rf_add13",    s(0, 0, 0, 0, 13, 1, 0, 0, 0, 1), e(0, 0, 12, 1, 0, 0, RUN, 9, 1));
    step("rf_frz",      s(0, 0, 0, 0, 13, 1, 0, 0, 0, 0), e(13, 1, 0, 0, 12, 1, FRZ, 9, 1));
    step("rf_async",    s(0, 0, 0, 0, 13, 1, 0, 0, 0, 0), e(0, 0, 0, 0, 0, 0, RUN, 0, 0));
    #2 rst_n = 1'b0;
    step("rf_hold",     idle,                             e(0, 0, 0, 0, 0, 0, RUN, 0, 0));
    @(negedge clk); #2 rst_n = 1'b1;
    step("rf_first",    s(0, 0, 0, 0, 5, 1, 0, 0, 0, 0),  e(0, 0, 0, 0, 0, 0, RUN, 0, 0));
    step("rf_second",   idle,                             e(5, 1, 0, 0, 0, 0, RUN, 0, 0));

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, need 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/hazard_tag_pipe.md
# hazard_tag_pipe

Destination-tag pipeline and hazard controller for the 5-stage RISC-V core. It carries each instruction's Rd, RegWrite, MemRead and memory-access flags from ID through ID/EX, EX/MEM and MEM/WB, and drives those tags to the forwarding logic. It also detects load-use hazards, applies branch flushes and freezes the pipe while the data memory is not ready. It supplies the PC, IF/ID and ID/EX control enables, a stall-cycle counter and a sticky memory-timeout flag.

## Interface
- MEM_TIMEOUT, 64: consecutive not-ready MEM cycles that set mem_timeout (1..65535).
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- IF_ID_Rs1, IF_ID_Rs2  in  5  source registers of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1  the ID instruction actually reads that source.
- id_rd  in  5  destination of the ID instruction.
- id_regwrite, id_memread, id_memacc  in  1  ID instruction writes Rd / is a load / is a load or store.
- ex_branch_taken  in  1  branch or jump in EX redirects the PC this cycle.
- mem_ready  in  1  data memory completes the MEM-stage access this cycle.
- ID_EX_Rd, EX_MEM_Rd, MEM_WB_Rd  out  5  registered destination tags.
- ID_EX_RegWrite, EX_MEM_RegWrite, MEM_WB_RegWrite  out  1  registered write enables.
- pc_write, if_id_write  out  1  PC and IF/ID load enables.
- if_id_flush, id_ex_bubble  out  1  squash IF/ID; load a bubble into ID/EX.
- stall_cycles  out  16  saturating count of cycles with pc_write=0.
- mem_timeout  out  1  sticky error flag.

## Operation
- Internal registered flags: ID_EX_MemRead, ID_EX_MemAcc, EX_MEM_MemAcc. Bubble = Rd 0, RegWrite 0, MemRead 0, MemAcc 0.
- freeze = EX_MEM_MemAcc & ~mem_ready.
- load_use = ID_EX_MemRead & ID_EX_Rd≠0 & ((id_uses_rs1 & ID_EX_Rd==IF_ID_Rs1) | (id_uses_rs2 & ID_EX_Rd==IF_ID_Rs2)).
- Priority: freeze > ex_branch_taken > load_use.
- While freeze is high:
  - ID/EX and EX/MEM hold.
  - MEM/WB loads a bubble.
  - pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=0.
  - ex_branch_taken is ignored; EX holds and re-presents it after the freeze.
- While ex_branch_taken is high and freeze is low:
  - pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1.
  - ID/EX loads a bubble; EX/MEM<=ID/EX; MEM/WB<=EX/MEM.
- While load_use is high alone:
  - pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0.
  - ID/EX loads a bubble; downstream stages advance.
- Otherwise:
  - All enables are 1, flush and bubble are 0.
  - ID/EX loads the id_* fields, gated so that id_rd==0 loads RegWrite 0.
  - EX/MEM<=ID/EX; MEM/WB<=EX/MEM.
- FSM:
  - RUN: freeze → MEM_WAIT with wait_cnt=1; otherwise stay in RUN.
  - MEM_WAIT: mem_ready → RUN with wait_cnt cleared; otherwise stay and increment wait_cnt (16 bit, saturating).
  - wait_cnt reaching MEM_TIMEOUT sets mem_timeout. It stays set until reset.
- stall_cycles increments on every clock edge at which pc_write=0 and saturates at 16'hFFFF.

## Timing
- Reset (rst_n low, asynchronous) values:
  - All tags, RegWrite and internal flags are 0.
  - FSM is in RUN; wait_cnt, stall_cycles and mem_timeout are 0.
  - Resulting outputs: pc_write=1, if_id_write=1, if_id_flush=ex_branch_taken, id_ex_bubble=ex_branch_taken.
- Reset mid-stall or mid-wait: state is lost immediately; the first edge after release behaves as from RUN with an empty pipe.
- Control outputs are combinational from registered state and the current inputs. Tag outputs change only on clock edges.
- A load-use stall lasts exactly one cycle: the bubble clears ID_EX_MemRead at the next edge.
- A freeze lasts as many cycles as mem_ready is low. The edge with mem_ready=1 advances normally.
- Simultaneous events:
  - Load-use during a freeze is resolved after the freeze.
  - Branch plus load-use → branch handling only.
  - stall_cycles saturated plus a new stall → holds 16'hFFFF.

## Test plan
- Normal advance: ID rd=5, regwrite=1, then 3 idle cycles → ID_EX_Rd=5 at edge 1, EX_MEM_Rd=5 at edge 2, MEM_WB_Rd=5 at edge 3, RegWrite following; all enables stay 1.
- Load-use: lw x7 followed by an ID instruction with rs1=7, id_uses_rs1=1 → one cycle with pc_write=0, if_id_write=0, id_ex_bubble=1; ID_EX_Rd=0 next; stall_cycles=1. The same case with id_uses_rs1=0, or with rd=x0, gives no stall.
- Branch: ex_branch_taken=1 coincident with a load-use match → if_id_flush=1, id_ex_bubble=1, pc_write=1; stall_cycles unchanged.
- Memory wait: store in EX/MEM with mem_ready=0 for 3 cycles → ID/EX and EX/MEM hold, MEM_WB_RegWrite=0 for 3 edges, stall_cycles=3; the state returns to RUN on the edge with mem_ready=1.
- Timeout: MEM_TIMEOUT=4 and mem_ready held low for 5 cycles → mem_timeout rises when wait_cnt reaches 4 and stays high after mem_ready returns until rst_n pulses low.
- Async reset asserted mid-freeze, not aligned to clk → all tags 0 and mem_timeout 0 immediately, pc_write=1.
